// File: rtl/washer_plant_model_if.sv
// Actuator/sensor bundle between the washer controller and the plant model.
// master = controller side (drives actuators, reads sensors);
// slave  = plant side (reads actuators, drives sensors).
interface washer_plant_model_if;
  logic        water_valve;
  logic        drain_pump;
  logic        heater;
  logic [10:0] drum_motor;
  logic [7:0]  load_weight;
  logic [2:0]  fault_inject;
  logic [9:0]  water_level_sensor;
  logic [6:0]  temperature_adc_sensor;
  logic        vibration_sensor;
  logic        overflow_flag;

  modport master (
    output water_valve, drain_pump, heater, drum_motor, load_weight, fault_inject,
    input  water_level_sensor, temperature_adc_sensor, vibration_sensor, overflow_flag
  );

  modport slave (
    input  water_valve, drain_pump, heater, drum_motor, load_weight, fault_inject,
    output water_level_sensor, temperature_adc_sensor, vibration_sensor, overflow_flag
  );
endinterface

// File: rtl/washer_plant_model.sv
// Washer plant model: water level, water temperature and drum vibration
// driven by the controller's actuator commands, with fault injection.
// Optional feature macro: PLANT_NOISE_EN adds LFSR jitter (+/-3) to the
// reported water level; the internal level stays noise-free.
module washer_plant_model #(
  parameter int FILL_RATE      = 25,
  parameter int DRAIN_RATE     = 50,
  parameter int LEVEL_MAX      = 1000,
  parameter int HEAT_MIN_LEVEL = 100,
  parameter int HEAT_DIV       = 4,
  parameter int COOL_DIV       = 16,
  parameter int AMBIENT_TEMP   = 20,
  parameter int TEMP_MAX       = 100,
  parameter int VIB_SPEED      = 800,
  parameter int VIB_LOAD       = 120,
  parameter int VIB_SETTLE     = 3,
  parameter int VIB_HOLD       = 4
) (
  input logic            clk,
  input logic            reset,
  washer_plant_model_if.slave plant
);

  localparam int DIV_W = $clog2((COOL_DIV > HEAT_DIV) ? COOL_DIV : HEAT_DIV);
  localparam int VC_W  = $clog2(((VIB_SETTLE > VIB_HOLD) ? VIB_SETTLE : VIB_HOLD) + 1);

  typedef enum logic [1:0] {MODE_COOL, MODE_HEAT, MODE_IDLE} heat_mode_e;
  typedef enum logic [1:0] {VIB_QUIET, VIB_SETTLING, VIB_SHAKING, VIB_DECAY} vib_state_e;

  logic        fill_eff, drain_eff, qualify;
  logic signed [11:0] lvl_sum;
  logic [9:0]  level_q, level_d;
  logic        ovf_q, ovf_d;
  logic [6:0]  temp_q, temp_d;
  logic [DIV_W-1:0] div_q, div_d, div_base;
  heat_mode_e  mode_q, mode_d;
  vib_state_e  vib_state_q;
  logic [VC_W-1:0] vib_cnt_q;
  logic        vib_q;

  assign fill_eff  = plant.water_valve & ~plant.fault_inject[0];
  assign drain_eff = plant.drain_pump  & ~plant.fault_inject[1];
  assign qualify   = (plant.drum_motor >= 11'(VIB_SPEED)) &&
                     ((plant.load_weight > 8'(VIB_LOAD)) || plant.fault_inject[2]);

  // Next water level: net fill/drain in signed arithmetic, clamped to [0, LEVEL_MAX].
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lvl_sum = $signed({2'b00, level_q});
    if (fill_eff)  lvl_sum = lvl_sum + $signed(12'(FILL_RATE));
    if (drain_eff) lvl_sum = lvl_sum - $signed(12'(DRAIN_RATE));
    if (lvl_sum < 0)                             level_d = '0;
    else if (lvl_sum > $signed(12'(LEVEL_MAX)))  level_d = 10'(LEVEL_MAX);
    else                                         level_d = lvl_sum[9:0];
    ovf_d = ovf_q | (fill_eff & (level_q == 10'(LEVEL_MAX)));
  end

  // Next temperature: divider counts in the current mode, restarting whenever the mode changes.
  always_comb begin
    if (!plant.heater)                             mode_d = MODE_COOL;
    else if (level_q >= 10'(HEAT_MIN_LEVEL))       mode_d = MODE_HEAT;
    else                                           mode_d = MODE_IDLE;
    div_base = (mode_d != mode_q) ? '0 : div_q;
    div_d    = div_base;
    temp_d   = temp_q;
    case (mode_d)
      MODE_HEAT: begin
        if (div_base == DIV_W'(HEAT_DIV - 1)) begin
          div_d = '0;
          if (temp_q < 7'(TEMP_MAX)) temp_d = temp_q + 7'd1;
        end else begin
          div_d = div_base + DIV_W'(1);
        end
      end
      MODE_COOL: begin
        if (div_base == DIV_W'(COOL_DIV - 1)) begin
          div_d = '0;
          if (temp_q > 7'(AMBIENT_TEMP)) temp_d = temp_q - 7'd1;
        end else begin
          div_d = div_base + DIV_W'(1);
        end
      end
      default: ; // dry heater: temperature and divider hold
    endcase
  end

  // Water and temperature state registers.
  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      temp_q  <= 7'(AMBIENT_TEMP);
      div_q   <= '0;
      mode_q  <= MODE_COOL;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      temp_q  <= temp_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
    end
  end

  // Vibration FSM with registered vibration output decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      vib_state_q <= VIB_QUIET;
      vib_cnt_q   <= '0;
      vib_q       <= 1'b0;
    end else begin
      case (vib_state_q)
        VIB_QUIET: begin
          vib_q <= 1'b0;
          if (qualify) begin
            vib_cnt_q   <= VC_W'(1);
            vib_state_q <= VIB_SETTLING;
          end else begin
            vib_cnt_q <= '0;
          end
        end
        VIB_SETTLING: begin
          if (!qualify) begin
            vib_cnt_q   <= '0;
            vib_state_q <= VIB_QUIET;
            vib_q       <= 1'b0;
          end else if (vib_cnt_q == VC_W'(VIB_SETTLE - 1)) begin
            vib_state_q <= VIB_SHAKING;
            vib_q       <= 1'b1;
          end else begin
            vib_cnt_q <= vib_cnt_q + VC_W'(1);
            vib_q     <= 1'b0;
          end
        end
        VIB_SHAKING: begin
          vib_q <= 1'b1;
          if (!qualify) begin
            vib_cnt_q   <= '0;
            vib_state_q <= VIB_DECAY;
          end
        end
        default: begin // VIB_DECAY
          if (qualify) begin
            vib_state_q <= VIB_SHAKING;
            vib_q       <= 1'b1;
          end else if (vib_cnt_q == VC_W'(VIB_HOLD - 1)) begin
            vib_cnt_q   <= '0;
            vib_state_q <= VIB_QUIET;
            vib_q       <= 1'b0;
          end else begin
            vib_cnt_q <= vib_cnt_q + VC_W'(1);
            vib_q     <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PLANT_NOISE_EN
  logic [7:0]  lfsr_q;
  logic [9:0]  level_rpt_q, level_rpt_d;
  logic signed [11:0] jitter, noisy;

  // Reported level = next internal level plus LFSR jitter, clamped to the legal range.
  always_comb begin
    jitter = (lfsr_q[2:0] == 3'b111) ? 12'sd0 : ($signed({9'b0, lfsr_q[2:0]}) - 12'sd3);
    noisy  = $signed({2'b00, level_d}) + jitter;
    if (noisy < 0)                             level_rpt_d = '0;
    else if (noisy > $signed(12'(LEVEL_MAX)))  level_rpt_d = 10'(LEVEL_MAX);
    else                                       level_rpt_d = noisy[9:0];
  end

  // Galois LFSR x^8+x^6+x^5+x^4+1 and the registered noisy level.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q      <= 8'hA5;
      level_rpt_q <= '0;
    end else begin
      lfsr_q      <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
      level_rpt_q <= level_rpt_d;
    end
  end

  assign plant.water_level_sensor = level_rpt_q;
`else
  assign plant.water_level_sensor = level_q;
`endif

  assign plant.temperature_adc_sensor = temp_q;
  assign plant.vibration_sensor       = vib_q;
  assign plant.overflow_flag          = ovf_q;

endmodule

// File: tb/tb_washer_plant_model.sv
// Self-checking bench for washer_plant_model: directed scenarios plus a
// randomized run, all checked against a behavioural plant model.
module tb_washer_plant_model;

  localparam int FILL_RATE = 25, DRAIN_RATE = 50, LEVEL_MAX = 1000;
  localparam int HEAT_MIN_LEVEL = 100, HEAT_DIV = 4, COOL_DIV = 16;
  localparam int AMBIENT_TEMP = 20, TEMP_MAX = 100;
  localparam int VIB_SPEED = 800, VIB_LOAD = 120, VIB_SETTLE = 3, VIB_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  washer_plant_model_if pif ();
  washer_plant_model dut (.clk(clk), .reset(reset), .plant(pif));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int level_m, temp_m, mode_clocks_m, mode_m, run_m, quiet_m;
  bit ovf_m, vib_m;

  function automatic bit lvl_eq(input int act, input int exp);
`ifdef PLANT_NOISE_EN
    return (act >= exp - 3) && (act <= exp + 3);
`else
    return act == exp;
`endif
  endfunction

  // One plant tick of the reference model, using the inputs present at the edge.
  function automatic void model_clock();
    int fill, drn, lvl, mode;
    bit q;
    if (reset) begin
      level_m = 0; temp_m = AMBIENT_TEMP; mode_clocks_m = 0; mode_m = 0;
      ovf_m = 0; vib_m = 0; run_m = 0; quiet_m = 0;
      return;
    end
    fill = (pif.water_valve && !pif.fault_inject[0]) ? 1 : 0;
    drn  = (pif.drain_pump  && !pif.fault_inject[1]) ? 1 : 0;
    if (fill == 1 && level_m == LEVEL_MAX) ovf_m = 1;
    // mode: 0 cooling, 1 heating, 2 dry heater
    mode = !pif.heater ? 0 : (level_m >= HEAT_MIN_LEVEL ? 1 : 2);
    if (mode != mode_m) mode_clocks_m = 0;
    mode_m = mode;
    if (mode == 1) begin
      mode_clocks_m++;
      if (mode_clocks_m == HEAT_DIV) begin
        mode_clocks_m = 0;
        if (temp_m < TEMP_MAX) temp_m++;
      end
    end else if (mode == 0) begin
      mode_clocks_m++;
      if (mode_clocks_m == COOL_DIV) begin
        mode_clocks_m = 0;
        if (temp_m > AMBIENT_TEMP) temp_m--;
      end
    end
    lvl = level_m + fill * FILL_RATE - drn * DRAIN_RATE;
    level_m = (lvl < 0) ? 0 : (lvl > LEVEL_MAX ? LEVEL_MAX : lvl);
    // Vibration: rises after VIB_SETTLE consecutive qualifying clocks,
    // falls on the (VIB_HOLD+1)-th consecutive non-qualifying clock.
    q = (int'(pif.drum_motor) >= VIB_SPEED) &&
        ((int'(pif.load_weight) > VIB_LOAD) || pif.fault_inject[2]);
    if (vib_m) begin
      if (q) quiet_m = 0;
      else begin
        quiet_m++;
        if (quiet_m == VIB_HOLD + 1) begin vib_m = 0; run_m = 0; end
      end
    end else begin
      if (q) begin
        run_m++;
        if (run_m == VIB_SETTLE) begin vib_m = 1; quiet_m = 0; end
      end else run_m = 0;
    end
  endfunction

  task automatic drive(input bit v, input bit d, input bit h, input int dm,
                       input int lw, input int fi);
    pif.water_valve  = v;
    pif.drain_pump   = d;
    pif.heater       = h;
    pif.drum_motor   = 11'(dm);
    pif.load_weight  = 8'(lw);
    pif.fault_inject = 3'(fi);
  endtask

  // Advance one clock; model updates at the edge, outputs settle by #1.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 1000, 200, 0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_cmp++; if (pif.water_level_sensor !== 10'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", pif.water_level_sensor); end
    n_cmp++; if (pif.temperature_adc_sensor !== 7'(AMBIENT_TEMP)) begin n_bad++; $display("FAIL reset_temp: got %0d expected %0d", pif.temperature_adc_sensor, AMBIENT_TEMP); end
    n_cmp++; if (pif.vibration_sensor !== 1'b0) begin n_bad++; $display("FAIL reset_vib: got %b expected 0", pif.vibration_sensor); end
    n_cmp++; if (pif.overflow_flag !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", pif.overflow_flag); end
  endtask

  task automatic test_fill();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), level_m)) begin n_bad++; $display("FAIL fill_level clk%0d: got %0d expected %0d", i, pif.water_level_sensor, level_m); end
    end
    n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), 300)) begin n_bad++; $display("FAIL fill_300: got %0d expected 300", pif.water_level_sensor); end
    n_cmp++; if (pif.overflow_flag !== 1'b0) begin n_bad++; $display("FAIL fill_ovf: got %b expected 0", pif.overflow_flag); end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 45; i++) begin
      step();
      if (i == 39) begin n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), 975)) begin n_bad++; $display("FAIL ovf_level39: got %0d expected 975", pif.water_level_sensor); end end
      if (i == 40) begin
        n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), 1000)) begin n_bad++; $display("FAIL ovf_level40: got %0d expected 1000", pif.water_level_sensor); end
        n_cmp++; if (pif.overflow_flag !== 1'b0) begin n_bad++; $display("FAIL ovf_flag40: got %b expected 0", pif.overflow_flag); end
      end
      if (i == 41) begin n_cmp++; if (pif.overflow_flag !== 1'b1) begin n_bad++; $display("FAIL ovf_flag41: got %b expected 1", pif.overflow_flag); end end
    end
    n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), 1000)) begin n_bad++; $display("FAIL ovf_level45: got %0d expected 1000", pif.water_level_sensor); end
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) step();
    n_cmp++; if (pif.overflow_flag !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", pif.overflow_flag); end
    do_reset();
    n_cmp++; if (pif.overflow_flag !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared: got %b expected 0", pif.overflow_flag); end
  endtask

  task automatic test_drain();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (12) step();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), (i <= 6) ? 300 - 50 * i : 0)) begin n_bad++; $display("FAIL drain_level clk%0d: got %0d expected %0d", i, pif.water_level_sensor, (i <= 6) ? 300 - 50 * i : 0); end
    end
    drive(1, 0, 0, 0, 0, 0);
    repeat (12) step();
    drive(0, 1, 0, 0, 0, 2);
    for (int i = 1; i <= 5; i++) begin
      step();
      n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), 300)) begin n_bad++; $display("FAIL drain_blocked clk%0d: got %0d expected 300", i, pif.water_level_sensor); end
    end
  endtask

  task automatic test_heat();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (12) step();
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 80; i++) begin
      step();
      n_cmp++; if (pif.temperature_adc_sensor !== 7'(temp_m)) begin n_bad++; $display("FAIL heat_temp clk%0d: got %0d expected %0d", i, pif.temperature_adc_sensor, temp_m); end
    end
    n_cmp++; if (pif.temperature_adc_sensor !== 7'd40) begin n_bad++; $display("FAIL heat_40: got %0d expected 40", pif.temperature_adc_sensor); end
    drive(0, 0, 0, 0, 0, 0);
    repeat (32) step();
    n_cmp++; if (pif.temperature_adc_sensor !== 7'd38) begin n_bad++; $display("FAIL cool_38: got %0d expected 38", pif.temperature_adc_sensor); end
    drive(0, 1, 0, 0, 0, 0);
    repeat (5) step();
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      n_cmp++; if (pif.temperature_adc_sensor !== 7'd38) begin n_bad++; $display("FAIL dry_heat clk%0d: got %0d expected 38", i, pif.temperature_adc_sensor); end
    end
  endtask

  task automatic test_vibration();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 0, 1000, 50, 4);
    for (int i = 1; i <= 10; i++) begin
      step();
      n_cmp++; if (pif.vibration_sensor !== 1'(i >= 3)) begin n_bad++; $display("FAIL vib_rise clk%0d: got %b expected %b", i, pif.vibration_sensor, i >= 3); end
    end
    drive(0, 0, 0, 1000, 50, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++; if (pif.vibration_sensor !== 1'(i <= 4)) begin n_bad++; $display("FAIL vib_fall clk%0d: got %b expected %b", i, pif.vibration_sensor, i <= 4); end
    end
    drive(0, 0, 0, 700, 50, 4);
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++; if (pif.vibration_sensor !== 1'b0) begin n_bad++; $display("FAIL vib_slow clk%0d: got %b expected 0", i, pif.vibration_sensor); end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 1000, 200, 0);
    repeat (8) step();
    n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), 200)) begin n_bad++; $display("FAIL mid_level: got %0d expected 200", pif.water_level_sensor); end
    n_cmp++; if (pif.vibration_sensor !== 1'b1) begin n_bad++; $display("FAIL mid_vib: got %b expected 1", pif.vibration_sensor); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (pif.water_level_sensor !== 10'd0) begin n_bad++; $display("FAIL mid_rst_level: got %0d expected 0", pif.water_level_sensor); end
    n_cmp++; if (pif.temperature_adc_sensor !== 7'(AMBIENT_TEMP)) begin n_bad++; $display("FAIL mid_rst_temp: got %0d expected %0d", pif.temperature_adc_sensor, AMBIENT_TEMP); end
    n_cmp++; if (pif.vibration_sensor !== 1'b0) begin n_bad++; $display("FAIL mid_rst_vib: got %b expected 0", pif.vibration_sensor); end
    n_cmp++; if (pif.overflow_flag !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovf: got %b expected 0", pif.overflow_flag); end
  endtask

  task automatic test_random();
    bit h = 0;
    int dm = 900, lw = 150, fi = 0;
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) h = !h;
      if ($urandom_range(0, 7) == 0) begin
        dm = $urandom_range(600, 1100);
        lw = $urandom_range(60, 200);
      end
      if ($urandom_range(0, 15) == 0) fi = $urandom_range(0, 7);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, h, dm, lw, fi);
      reset = ($urandom_range(0, 299) == 0);
      step();
      n_cmp++; if (!lvl_eq(int'(pif.water_level_sensor), level_m)) begin n_bad++; $display("FAIL rnd_level #%0d: got %0d expected %0d", i, pif.water_level_sensor, level_m); end
      n_cmp++; if (pif.temperature_adc_sensor !== 7'(temp_m)) begin n_bad++; $display("FAIL rnd_temp #%0d: got %0d expected %0d", i, pif.temperature_adc_sensor, temp_m); end
      n_cmp++; if (pif.vibration_sensor !== vib_m) begin n_bad++; $display("FAIL rnd_vib #%0d: got %b expected %b", i, pif.vibration_sensor, vib_m); end
      n_cmp++; if (pif.overflow_flag !== ovf_m) begin n_bad++; $display("FAIL rnd_ovf #%0d: got %b expected %b", i, pif.overflow_flag, ovf_m); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_heat();
    test_vibration();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
Synthesizable plant model forming the opposite end of the MainController actuator/sensor interface. It consumes the controller's actuator outputs (water_valve, drain_pump, heater, drum_motor) and produces the sensor inputs the controller reads (water_level_sensor, temperature_adc_sensor, vibration_sensor). Benches and FPGA demo builds use it to close the loop, with fault injection for error-path checks.

Parameters:
FILL_RATE, 25, level units added per clock while filling
DRAIN_RATE, 50, level units removed per clock while draining
LEVEL_MAX, 1000, water level saturation ceiling (must be <= 1023)
HEAT_MIN_LEVEL, 100, minimum water level for heating to take effect
HEAT_DIV, 4, clocks per +1 degree while heating
COOL_DIV, 16, clocks per -1 degree while not heating
AMBIENT_TEMP, 20, reset and cooling floor temperature
TEMP_MAX, 100, heating ceiling (must be <= 127)
VIB_SPEED, 800, drum_motor threshold for imbalance-prone spinning
VIB_LOAD, 120, load_weight above which imbalance occurs at speed
VIB_SETTLE, 3, consecutive qualifying clocks before vibration asserts
VIB_HOLD, 4, clocks vibration persists after condition clears

Ports:
clk  input  1  system clock, one plant tick per rising edge
reset  input  1  synchronous, active-high reset
water_valve  input  1  inlet valve command from controller
drain_pump  input  1  drain pump command from controller
heater  input  1  heater command from controller
drum_motor  input  11  commanded drum speed (rpm)
load_weight  input  8  load mass presented to drum
fault_inject  input  3  bit0 inlet blocked, bit1 drain blocked, bit2 forced imbalance
water_level_sensor  output  10  modelled water level
temperature_adc_sensor  output  7  modelled water temperature
vibration_sensor  output  1  excessive vibration indication
overflow_flag  output  1  sticky: fill commanded while at LEVEL_MAX

Behaviour:
- Reset (sync, active-high; takes priority over all other inputs, including mid-fill or mid-vibration): water_level_sensor=0, temperature_adc_sensor=AMBIENT_TEMP, vibration_sensor=0, overflow_flag=0, all dividers/counters 0, vibration FSM in QUIET.
- All outputs are registered. Inputs sampled at edge N are reflected at outputs after edge N (one-clock latency).
- Water level, per clock:
  - fill_eff = water_valve & ~fault_inject[0]; drain_eff = drain_pump & ~fault_inject[1].
  - next = level + (fill_eff ? FILL_RATE : 0) - (drain_eff ? DRAIN_RATE : 0), computed in 12-bit signed arithmetic.
  - Clamp next to the range [0, LEVEL_MAX]. Both active gives the net difference.
  - overflow_flag sets when fill_eff=1 and level==LEVEL_MAX; it is cleared only by reset.
- Temperature:
  - Heating is active when heater=1 and level>=HEAT_MIN_LEVEL. A dry heater has no effect; it does not heat and does not cool.
  - While heating, the divider counts 0..HEAT_DIV-1. On wrap, temp+1, saturating at TEMP_MAX.
  - While heater=0, the divider counts 0..COOL_DIV-1. On wrap, temp-1, floored at AMBIENT_TEMP.
  - Any change of heating mode clears the divider in the same clock.
- Vibration FSM (qualify = drum_motor>=VIB_SPEED and (load_weight>VIB_LOAD or fault_inject[2])):
  - QUIET: counter=0, vib=0. On qualify: counter=1, go to SETTLING.
  - SETTLING: vib=0. If qualify and counter==VIB_SETTLE-1: go to SHAKING. If qualify otherwise: counter+1. If not qualify: go to QUIET.
  - SHAKING: vib=1. On !qualify: counter=0, go to DECAY.
  - DECAY: vib=1. On qualify: go to SHAKING. If counter==VIB_HOLD-1: go to QUIET (vib=0 next). Otherwise counter+1.
  - vibration_sensor is a registered decode of the state.
  - Net effect: vib rises VIB_SETTLE clocks after qualify first seen, and falls VIB_HOLD clocks after qualify drops.

Optional Feature:
PLANT_NOISE_EN:
- Defined: an 8-bit Galois LFSR (taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every clock. Reported water_level_sensor = internal level + signed jitter in [-3,+3] taken from LFSR[2:0] (value 3'b111 maps to 0), clamped to [0, LEVEL_MAX]. The internal level used for the heating threshold is noise-free.
- Undefined: the reported level equals the internal level exactly and no LFSR is instantiated.

Test Plan:
- Reset, then water_valve=1 for 12 clocks -> water_level_sensor=300; overflow_flag=0.
- Valve held 45 clocks -> level saturates at 1000 on clock 40; overflow_flag=1 and stays 1 after the valve drops, until reset.
- Level 300, drain_pump=1 -> 250, 200, ... 0 after 6 clocks, then holds 0. Same with fault_inject[1]=1 -> level stays 300.
- Level 300, heater=1 for 80 clocks -> temp 20 to 40. Heater=0 for 32 clocks -> 38. Heater=1 at level 50 -> temp unchanged.
- drum_motor=1000, load_weight=50, fault_inject[2]=1 -> vib=1 on 3rd clock. Clear fault after 10 clocks -> vib=0 exactly 4 clocks later. drum_motor=700 with same load -> vib never asserts.
- Assert reset mid-fill (level 200) during SHAKING -> next clock: level=0, temp=20, vib=0, overflow_flag=0.
